// File: rtl/gain_update_pkg.sv
// gain_update_pkg: fixed-point helpers shared by the gain updater and its channels.
package gain_update_pkg;
  function automatic longint fx(input int g, input int fw);
    return longint'(g) <<< fw;
  endfunction
  function automatic int acc_w(input int iw, input int decim);
    return iw + $clog2(decim) + 1;
  endfunction
  function automatic int sum_w(input int gw, input int fw, input int iw, input int decim);
    return gw + fw + iw + $clog2(decim) + 2;
  endfunction
  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
endpackage

// File: rtl/gain_update_ch.sv
// gain_update_ch: one channel's stored gain, increment accumulator, clamp, load and bound flags.
module gain_update_ch
  import gain_update_pkg::*;
#(
  parameter int GW    = 8,
  parameter int FW    = 4,
  parameter int IW    = 8,
  parameter int DECIM = 1,
  parameter int GMIN  = 3,
  parameter int GMAX  = 128,
  parameter int GINIT = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_acc_en,
  input  logic                 i_apply,
  input  logic                 i_load,
  input  logic signed [IW-1:0] i_inc,
  input  logic [GW-1:0]        i_load_val,
  output logic [GW-1:0]        o_gain,
  output logic                 o_at_min,
  output logic                 o_at_max
);
  localparam int NW = GW + FW;
  localparam int AW = acc_w(IW, DECIM);
  localparam int SW = sum_w(GW, FW, IW, DECIM);
  localparam longint GMIN_FX  = fx(GMIN, FW);
  localparam longint GMAX_FX  = fx(GMAX, FW);
  localparam longint GINIT_FX = fx(GINIT, FW);
  logic [NW-1:0]        r_g;
  logic signed [AW-1:0] r_acc;
  logic signed [SW-1:0] w_sum;
  logic [NW-1:0]        w_clamped;
  // Sum is wide and signed so under/overflow clamps instead of wrapping; clamping
  // before or after the <<FW of a loaded value gives the same result.
  assign w_sum     = SW'($signed({1'b0, r_g})) + SW'(r_acc) + SW'(i_inc);
  assign w_clamped = NW'(clamp(i_load ? fx(int'(i_load_val), FW) : longint'(w_sum), GMIN_FX, GMAX_FX));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g   <= NW'(GINIT_FX);
      r_acc <= '0;
    end else begin
      if (i_load || i_apply) r_g <= w_clamped;
      r_acc <= (i_load || i_apply) ? '0 : i_acc_en ? r_acc + AW'(i_inc) : r_acc;
    end
  end
  assign o_gain   = r_g[NW-1:FW];
  assign o_at_min = r_g == NW'(GMIN_FX);
  assign o_at_max = r_g == NW'(GMAX_FX);
endmodule

// File: rtl/gain_update.sv
// gain_update: NCH clamped fixed-point loop gains updated from decimated signed increments.
module gain_update
  import gain_update_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int GW    = 8,
  parameter int FW    = 4,
  parameter int IW    = 8,
  parameter int DECIM = 1,
  parameter int GMIN  = 3,
  parameter int GMAX  = 128,
  parameter int GINIT = 12,
  localparam int LW   = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_valid,
  input  logic [NCH*IW-1:0] inc,
  input  logic              freeze,
  input  logic              load,
  input  logic [LW-1:0]     load_ch,
  input  logic [GW-1:0]     load_val,
  output logic [NCH*GW-1:0] gain,
  output logic [NCH-1:0]    at_min,
  output logic [NCH-1:0]    at_max,
  output logic              upd_strobe
);
  localparam int CW = DECIM > 1 ? $clog2(DECIM) : 1;
  logic [CW-1:0] r_cnt;
  logic          w_step, w_apply, w_acc_en;
  assign w_step   = inc_valid && !freeze;
  assign w_apply  = w_step && r_cnt == CW'(DECIM - 1);
  assign w_acc_en = w_step && !w_apply;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      upd_strobe <= 1'b0;
    end else begin
      r_cnt      <= w_apply ? '0 : w_acc_en ? r_cnt + CW'(1) : r_cnt;
      upd_strobe <= w_apply;
    end
  end
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    gain_update_ch #(
      .GW(GW), .FW(FW), .IW(IW), .DECIM(DECIM), .GMIN(GMIN), .GMAX(GMAX), .GINIT(GINIT)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_acc_en  (w_acc_en),
      .i_apply   (w_apply),
      .i_load    (load && load_ch == LW'(k)),
      .i_inc     (inc[k*IW +: IW]),
      .i_load_val(load_val),
      .o_gain    (gain[k*GW +: GW]),
      .o_at_min  (at_min[k]),
      .o_at_max  (at_max[k])
    );
  end
endmodule
